linebuffer_ring: RTL and testbench
==================================

Name: linebuffer_ring

Overview:
- Single-clock N-way line buffer ring; the parametrised successor to the two-buffer on/off scheme.
- Holds NUM_BUF line buffers. One is on-screen (read per pixel), one is off-screen (written LANES pixels per word), and the rest are spare.
- On flip, the retired on-screen buffer is cleared internally by a sequencer. With NUM_BUF>=3, drawing continues into a clean spare while that clear runs.
- Sits between the sprite/tile draw engine and the scanout path where both run on clk_draw.

Parameters:
- NUM_BUF, 3, number of line buffers; legal 2..4.
- PIX_W, 9, bits per pixel.
- LANES, 8, pixels per write word; power of 2.
- LINE_PIX, 4096, pixels per buffer; multiple of LANES.
- CLEAR_COLOUR, 0, PIX_W-bit value written by clears.
- Derived: WORDS=LINE_PIX/LANES, PA_W=$clog2(LINE_PIX), WA_W=$clog2(WORDS).

Ports:
- clk_draw  in  1  sole clock, rising edge.
- rst_draw_n  in  1  asynchronous reset, active-low.
- flip_req  in  1  level request to flip; hold until flip_ack.
- flip_ack  out  1  one-cycle pulse, flip accepted this cycle.
- rd_addr  in  PA_W  on-screen pixel read address.
- rd_colour  out  PIX_W  pixel at rd_addr, registered.
- wr_addr  in  WA_W  off-screen word address.
- wr_we  in  LANES  per-lane write enables; lane i = pixel wr_addr*LANES+i.
- wr_colour  in  LANES*PIX_W  lane i at bits [i*PIX_W +: PIX_W].
- wr_ready  out  1  off-screen buffer writable.
- wr_drop  out  1  one-cycle pulse: write with any wr_we bit set arrived while wr_ready=0.
- on_idx  out  $clog2(NUM_BUF)  current on-screen buffer.
- off_idx  out  $clog2(NUM_BUF)  current off-screen buffer.
- busy  out  1  clear sequencer active.

Behaviour:
- Reset values:
  - on_idx=0, off_idx=1, flip_ack=0, wr_drop=0, rd_colour=CLEAR_COLOUR.
  - State enters INIT; busy=1, wr_ready=0.
- FSM states: INIT, IDLE, CLEAR.
  - INIT clears every buffer, one word per cycle, all lanes: buffer 0 words 0..WORDS-1, then buffer 1, and so on. This takes NUM_BUF*WORDS cycles, then the FSM goes to IDLE.
  - CLEAR writes CLEAR_COLOUR to the retired buffer, words 0..WORDS-1, one per cycle. It returns to IDLE after the write of word WORDS-1.
- Flip acceptance: only in IDLE with flip_req=1. In the accepting cycle:
  - flip_ack=1.
  - on_idx<=off_idx.
  - off_idx<=(off_idx+1) mod NUM_BUF.
  - Retired buffer = old on_idx; state<=CLEAR.
- flip_req in INIT or CLEAR is held off: no ack until IDLE. Ack comes on the first IDLE cycle.
- NUM_BUF=2: the new off buffer is the one being cleared, so wr_ready=0 for WORDS cycles after the flip.
- NUM_BUF>=3: the new off buffer is always clean, so wr_ready stays 1 through CLEAR.
- wr_ready = (state!=INIT) && !(state==CLEAR && clear_idx==off_idx).
- Write rules:
  - A write lands when wr_ready=1, in the same cycle, into off_idx.
  - In a flip cycle, writes use the pre-flip off_idx.
  - A write with wr_ready=0 is discarded and pulses wr_drop next cycle.
  - Lanes with wr_we[i]=0 are unchanged.
- Read path:
  - 1-cycle latency: rd_colour at edge N+1 reflects rd_addr and on_idx sampled at edge N.
  - Lane select is rd_addr[$clog2(LANES)-1:0].
  - A read in a flip cycle returns the old on buffer; the next cycle returns the new one.
  - In INIT, rd_colour is forced to CLEAR_COLOUR.
- Clear port and draw port target different buffers by construction. There is no arbitration and no collision.
- Reset asserted mid-CLEAR or mid-INIT aborts immediately. On release, a full INIT restarts.
- Addresses wrap naturally within PA_W/WA_W. Out-of-range addresses (LINE_PIX not a power of 2) are ignored for writes and read back as CLEAR_COLOUR.

Optional Feature:
- Macro LINEBUFFER_RING_TRANSPARENT_EN.
- Defined: a draw-port lane is written only if wr_we[i]=1 and its colour != 0. Colour 0 is transparent, so later sprites do not overwrite with holes. Clears are unaffected.
- Not defined: wr_we alone gates each lane.

Test Plan:
- Reset with NUM_BUF=3, WORDS=512 -> busy=1, wr_ready=0 for 1536 cycles; then IDLE, wr_ready=1, and every rd_addr reads 0.
- Write word 5, wr_we=8'hFF, lanes=1..8; flip; read pixels 40..47 -> 1..8 one cycle after each address. on_idx=1, off_idx=2.
- Flip again after first flip -> flip_ack delayed until CLEAR of buffer 0 completes (512 cycles). Then on=2, off=0, and buffer 0 reads all 0 after a third flip.
- NUM_BUF=2: flip, write during the following 512 cycles -> wr_ready=0, wr_drop pulses, data absent; write at cycle 513 -> lands.
- Write with wr_we=8'b0000_0100 onto a word pre-filled with 7s -> only lane 2 changes. With LINEBUFFER_RING_TRANSPARENT_EN and colour 0 on lane 2, lane 2 stays 7.
- Assert rst_draw_n low at word 200 of CLEAR -> outputs return to reset values asynchronously, and a full INIT reruns.

Source files
------------

// File: rtl/linebuffer_ring.sv
// linebuffer_ring: NUM_BUF-way line buffer ring with an on-screen read port, an off-screen lane-masked write port and a clear sequencer
// Ports:
//   clk_draw, rst_draw_n       sole clock (rising edge), asynchronous active-low reset
//   flip_req / flip_ack        level flip request, one-cycle acceptance pulse
//   rd_addr / rd_colour        on-screen pixel address, registered pixel (1-cycle latency)
//   wr_addr, wr_we, wr_colour  off-screen word address, per-lane enables, packed lane colours
//   wr_ready / wr_drop         off-screen buffer writable, pulse after a discarded write
//   on_idx, off_idx, busy      current buffer indices, clear sequencer active
// Optional: define LINEBUFFER_RING_TRANSPARENT_EN to treat colour 0 on the draw port as transparent.
module linebuffer_ring #(
  parameter int NUM_BUF = 3,
  parameter int PIX_W = 9,
  parameter int LANES = 8,
  parameter int LINE_PIX = 4096,
  parameter logic [PIX_W-1:0] CLEAR_COLOUR = '0,
  localparam int WORDS = LINE_PIX / LANES,
  localparam int PA_W = $clog2(LINE_PIX),
  localparam int WA_W = $clog2(WORDS),
  localparam int IW = $clog2(NUM_BUF),
  localparam int LS_W = $clog2(LANES)
) (
  input  logic                   clk_draw,
  input  logic                   rst_draw_n,
  input  logic                   flip_req,
  output logic                   flip_ack,
  input  logic [PA_W-1:0]        rd_addr,
  output logic [PIX_W-1:0]       rd_colour,
  input  logic [WA_W-1:0]        wr_addr,
  input  logic [LANES-1:0]       wr_we,
  input  logic [LANES*PIX_W-1:0] wr_colour,
  output logic                   wr_ready,
  output logic                   wr_drop,
  output logic [IW-1:0]          on_idx,
  output logic [IW-1:0]          off_idx,
  output logic                   busy
);
  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;
  state_t state_q;
  logic [IW-1:0] on_q, off_q, clr_buf_q;
  logic [WA_W-1:0] clr_word_q;
  logic drop_q;
  logic [PIX_W-1:0] rd_q, rd_d;
  logic [LANES*PIX_W-1:0] mem_q [NUM_BUF][WORDS];
  logic [LANES*PIX_W-1:0] rd_word;
  logic [LANES-1:0] lane_we;
  logic clr_last, wr_ok, rd_ok;
  assign clr_last = clr_word_q == WA_W'(WORDS - 1);
  assign busy = state_q != IDLE;
  assign wr_ready = state_q != INIT && !(state_q == CLEAR && clr_buf_q == off_q);
  assign flip_ack = state_q == IDLE && flip_req;
  // addresses past LINE_PIX only exist when LINE_PIX is not a power of two
  assign wr_ok = wr_ready && {1'b0, wr_addr} < (WA_W + 1)'(WORDS);
  assign rd_ok = state_q != INIT && {1'b0, rd_addr} < (PA_W + 1)'(LINE_PIX);
  assign rd_word = mem_q[on_q][rd_addr[PA_W-1:LS_W]];
  assign rd_colour = rd_q;
  assign wr_drop = drop_q;
  assign on_idx = on_q;
  assign off_idx = off_q;
`ifdef LINEBUFFER_RING_TRANSPARENT_EN
  always_comb begin
    lane_we = '0;
    for (int i = 0; i < LANES; i++)
      lane_we[i] = wr_we[i] && wr_colour[i*PIX_W +: PIX_W] != '0;
  end
`else
  assign lane_we = wr_we;
`endif
  always_comb rd_d = rd_ok ? rd_word[int'(rd_addr[LS_W-1:0]) * PIX_W +: PIX_W] : CLEAR_COLOUR;
  always_ff @(posedge clk_draw or negedge rst_draw_n)
    if (!rst_draw_n) begin
      state_q <= INIT;
      on_q <= '0;
      off_q <= IW'(1);
      clr_buf_q <= '0;
      clr_word_q <= '0;
      drop_q <= 1'b0;
      rd_q <= CLEAR_COLOUR;
    end else begin
      drop_q <= |wr_we && !wr_ready;
      rd_q <= rd_d;
      case (state_q)
        INIT: begin
          clr_word_q <= clr_last ? '0 : clr_word_q + 1'b1;
          if (clr_last) begin
            if (clr_buf_q == IW'(NUM_BUF - 1)) state_q <= IDLE;
            else clr_buf_q <= clr_buf_q + 1'b1;
          end
        end
        IDLE: if (flip_req) begin
          on_q <= off_q;
          off_q <= off_q == IW'(NUM_BUF - 1) ? '0 : off_q + 1'b1;
          clr_buf_q <= on_q;
          state_q <= CLEAR;
        end
        CLEAR: begin
          clr_word_q <= clr_last ? '0 : clr_word_q + 1'b1;
          if (clr_last) state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  // the sequencer and the draw port never address the same buffer in one cycle
  always_ff @(posedge clk_draw) begin
    if (state_q != IDLE) mem_q[clr_buf_q][clr_word_q] <= {LANES{CLEAR_COLOUR}};
    if (wr_ok)
      for (int i = 0; i < LANES; i++)
        if (lane_we[i]) mem_q[off_q][wr_addr][i*PIX_W +: PIX_W] <= wr_colour[i*PIX_W +: PIX_W];
  end
endmodule

// File: tb/tb_linebuffer_ring.sv
// tb_linebuffer_ring: checks a 3-buffer and a 2-buffer ring against a pixel-array model of the ring
module tb_linebuffer_ring;
  localparam int LP = 4096;
`ifdef LINEBUFFER_RING_TRANSPARENT_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req [2], ack [2], rdy [2], drop [2], busy [2];
  logic [11:0] ra [2];
  logic [8:0] rc [2], wa [2];
  logic [7:0] we [2];
  logic [71:0] wc [2];
  logic [1:0] on3, off3;
  logic on2, off2;
  linebuffer_ring u3 (.clk_draw(clk), .rst_draw_n(rst_n), .flip_req(req[0]), .flip_ack(ack[0]),
    .rd_addr(ra[0]), .rd_colour(rc[0]), .wr_addr(wa[0]), .wr_we(we[0]), .wr_colour(wc[0]),
    .wr_ready(rdy[0]), .wr_drop(drop[0]), .on_idx(on3), .off_idx(off3), .busy(busy[0]));
  linebuffer_ring #(.NUM_BUF(2)) u2 (.clk_draw(clk), .rst_draw_n(rst_n), .flip_req(req[1]), .flip_ack(ack[1]),
    .rd_addr(ra[1]), .rd_colour(rc[1]), .wr_addr(wa[1]), .wr_we(we[1]), .wr_colour(wc[1]),
    .wr_ready(rdy[1]), .wr_drop(drop[1]), .on_idx(on2), .off_idx(off2), .busy(busy[1]));
  logic [8:0] m [2][3][LP];
  int nb [2] = '{3, 2};
  int mon [2], moff [2], cbuf [2], cend [2], iend [2];
  int hist [2][$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { int wa; logic [7:0] we; logic [71:0] wc; int rp; int rx; } vec_t;
  vec_t v [12];
  function automatic int on_of(int d);
    return d == 0 ? int'(on3) : int'(on2);
  endfunction
  function automatic int off_of(int d);
    return d == 0 ? int'(off3) : int'(off2);
  endfunction
  function automatic bit m_ready(int d);
    return cyc >= cend[d] || (cyc >= iend[d] && cbuf[d] != moff[d]);
  endfunction
  function automatic logic [71:0] rnd_word();
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i*9 +: 9] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
    return w;
  endfunction
  function automatic logic [71:0] fill(int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i*9 +: 9] = 9'(c);
    return w;
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mon[d] = 0; moff[d] = 1; cbuf[d] = 0;
      iend[d] = cyc + nb[d] * 512; cend[d] = iend[d];
      for (int b = 0; b < 3; b++) for (int p = 0; p < LP; p++) m[d][b][p] = '0;
      hist[d].delete();
    end
  endtask
  task automatic wr(int d, int a, logic [7:0] e, logic [71:0] c);
    bit r;
    r = m_ready(d);
    wa[d] = 9'(a); we[d] = e; wc[d] = c;
    #1;
    chk("wr_ready", rdy[d], r);
    if (r)
      for (int i = 0; i < 8; i++)
        if (e[i] && (!TR || c[i*9 +: 9] != 0)) begin
          m[d][moff[d]][a*8+i] = c[i*9 +: 9];
          hist[d].push_back(a*8+i);
        end
    @(negedge clk);
    we[d] = '0;
    #1;
    chk("wr_drop", drop[d], !r && e != 0);
  endtask
  task automatic rd(int d, int p, int exp, string nm);
    ra[d] = 12'(p);
    @(negedge clk);
    #1;
    chk(nm, rc[d], exp);
  endtask
  task automatic flip(int d, output int n);
    int w;
    n = 0;
    w = cend[d] > cyc ? cend[d] - cyc : 0;
    req[d] = 1'b1;
    #1;
    while (!ack[d] && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("flip_wait", n, w);
    if (ack[d]) begin
      cbuf[d] = mon[d];
      for (int p = 0; p < LP; p++) m[d][mon[d]][p] = '0;
      mon[d] = moff[d];
      moff[d] = (moff[d] + 1) % nb[d];
      cend[d] = cyc + 513;
    end
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    @(negedge clk);
    #1;
    chk("on_idx", on_of(d), mon[d]);
    chk("off_idx", off_of(d), moff[d]);
  endtask
  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, n2, n3, p;
    logic [71:0] w;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; ra[d] = '0; wa[d] = '0; we[d] = '0; wc[d] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_on", on_of(d), 0); chk("rst_off", off_of(d), 1);
      chk("rst_busy", busy[d], 1); chk("rst_ready", rdy[d], 0);
      chk("rst_ack", ack[d], 0); chk("rst_drop", drop[d], 0); chk("rst_rd", rc[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n2 = -1; n3 = -1;
    for (int k = 1; k <= 2000 && n3 < 0; k++) begin
      @(negedge clk);
      #1;
      if (k == 100) begin
        chk("init_ready3", rdy[0], 0); chk("init_ready2", rdy[1], 0);
      end
      if (!busy[1] && n2 < 0) n2 = k;
      if (!busy[0]) n3 = k;
    end
    chk("init_len3", n3, 1536);
    chk("init_len2", n2, 1024);
    chk("idle_ready3", rdy[0], 1);
    for (int i = 0; i < 4; i++) rd(0, $urandom_range(0, LP - 1), 0, "init_zero");
    v[0] = '{wa: 5, we: 8'hFF, wc: '0, rp: 40, rx: 1};
    for (int i = 0; i < 8; i++) v[0].wc[i*9 +: 9] = 9'(i + 1);
    for (int i = 1; i < 8; i++) v[i] = '{wa: 0, we: 8'h00, wc: '0, rp: 40 + i, rx: i + 1};
    v[8] = '{wa: 6, we: 8'h04, wc: '0, rp: 50, rx: 'h1AB};
    v[8].wc[2*9 +: 9] = 9'h1AB;
    v[9] = '{wa: 0, we: 8'h00, wc: '0, rp: 49, rx: 0};
    v[10] = '{wa: 511, we: 8'h80, wc: '0, rp: 4095, rx: 'h1FF};
    v[10].wc[7*9 +: 9] = 9'h1FF;
    v[11] = '{wa: 0, we: 8'h00, wc: '0, rp: 0, rx: 0};
    for (int i = 0; i < 12; i++) if (v[i].we != 0) wr(0, v[i].wa, v[i].we, v[i].wc);
    flip(0, n);
    chk("flip1_on", on3, 1); chk("flip1_off", off3, 2);
    for (int i = 0; i < 12; i++) rd(0, v[i].rp, v[i].rx, "vec_rd");
    wr(0, 10, 8'hFF, fill(7));
    w = fill('h155);
    w[2*9 +: 9] = 9'd3;
    wr(0, 10, 8'h04, w);
    wr(0, 11, 8'hFF, fill(7));
    wr(0, 11, 8'h04, '0);
    flip(0, n);
    chk("flip2_on", on3, 2); chk("flip2_off", off3, 0);
    for (int i = 0; i < 8; i++) rd(0, 80 + i, i == 2 ? 3 : 7, "mask_rd");
    for (int i = 0; i < 8; i++) rd(0, 88 + i, (i == 2 && !TR) ? 0 : 7, "transp_rd");
    flip(0, n);
    flip(0, n);
    chk("double_flip_delay", n, 512);
    chk("flip4_on", on3, 1);
    for (int i = 0; i < 8; i++) rd(0, 40 + i, 0, "cleared_rd");
    wr(1, 3, 8'hFF, fill(5));
    flip(1, n);
    wr(1, 20, 8'hFF, fill(9));
    while (cyc < cend[1] - 1) begin
      @(negedge clk);
      #1;
    end
    chk("n2_last_clear_ready", rdy[1], 0);
    wr(1, 21, 8'hFF, fill(10));
    wr(1, 22, 8'hFF, fill(11));
    flip(1, n);
    chk("n2_flip_nowait", n, 0);
    for (int i = 0; i < 8; i += 3) begin
      rd(1, 20*8 + i, 0, "n2_drop_absent");
      rd(1, 21*8 + i, 0, "n2_drop_absent");
      rd(1, 22*8 + i, 11, "n2_late_write");
    end
    for (int k = 0; k < 400; k++) begin
      int d, r;
      d = k % 2;
      r = $urandom_range(0, 39);
      if (r == 0) flip(d, n);
      else if (r < 20) wr(d, $urandom_range(0, 511), 8'($urandom), rnd_word());
      else begin
        if (hist[d].size() > 0 && $urandom_range(0, 2) != 0) p = hist[d][$urandom_range(0, hist[d].size() - 1)];
        else p = $urandom_range(0, LP - 1);
        rd(d, p, m[d][mon[d]][p], "rand_rd");
      end
    end
    while (moff[0] != 0) flip(0, n);
    for (int i = 0; i < 8; i++) w[i*9 +: 9] = 9'(100 + i);
    wr(0, 500, 8'hFF, w);
    flip(0, n);
    rd(0, 500*8 + 3, 103, "pre_reset_rd");
    repeat (198) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_on", on_of(d), 0); chk("arst_off", off_of(d), 1);
      chk("arst_busy", busy[d], 1); chk("arst_ready", rdy[d], 0);
      chk("arst_drop", drop[d], 0); chk("arst_rd", rc[d], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    #1;
    chk("init_rd_forced", rc[0], 0);
    flip(0, n);
    for (int i = 0; i < 8; i++) rd(0, $urandom_range(0, LP - 1), 0, "reinit_zero");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
